cpu_control_fsm: RTL and testbench

- Multi-cycle controller for the simple 16-bit CPU. It sits directly upstream of the register_16bit instances (IR, PC, register file, flag register) and drives their enable/load strobes.
- Sequences FETCH/DECODE/EXEC/WB over a single-ported memory with a ready handshake.
- Decodes the instruction already held in the external IR (fed back on ir_in). Produces ALU op, register addresses, writeback select and immediate.

---
 rtl/cpu_pkg.sv | 66 ++++++
 rtl/cpu_instr_decode.sv | 52 +++++
 rtl/cpu_control_fsm.sv | 207 ++++++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU controller: opcodes, FSM states,
// ALU and writeback codes, instruction field positions.
package cpu_pkg;

  localparam int DATA_W  = 16;
  localparam int RADDR_W = 3;

  localparam int OP_LSB    = 12;
  localparam int RD_LSB    = 9;
  localparam int RS_LSB    = 6;
  localparam int RT_LSB    = 3;
  localparam int LDI_IMM_W = 9;
  localparam int JMP_IMM_W = 12;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_IMM = 2'd1;
  localparam logic [1:0] WB_MEM = 2'd2;
  localparam logic [1:0] WB_RS  = 2'd3;

  typedef enum logic [3:0] {
    CLS_NOP  = 4'd0,
    CLS_ALU  = 4'd1,
    CLS_LDI  = 4'd2,
    CLS_MOV  = 4'd3,
    CLS_LD   = 4'd4,
    CLS_ST   = 4'd5,
    CLS_JMP  = 4'd6,
    CLS_JZ   = 4'd7,
    CLS_HALT = 4'd8
  } instr_class_e;

  function automatic logic [DATA_W-1:0] sext_ldi(input logic [LDI_IMM_W-1:0] f);
    return {{(DATA_W-LDI_IMM_W){f[LDI_IMM_W-1]}}, f};
  endfunction

endpackage

// File: rtl/cpu_instr_decode.sv
// Combinational instruction decoder: opcode -> class, ALU op, writeback
// source, immediate and illegal flag.
module cpu_instr_decode
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] instr_i,
  output instr_class_e      cls_o,
  output logic [2:0]        alu_op_o,
  output logic [1:0]        wb_sel_o,
  output logic [DATA_W-1:0] imm_o,
  output logic              illegal_o
);

  logic [3:0] op;
  assign op = instr_i[OP_LSB +: 4];

  always_comb begin
    cls_o     = CLS_NOP;
    alu_op_o  = ALU_ADD;
    wb_sel_o  = WB_ALU;
    imm_o     = '0;
    illegal_o = 1'b0;
    case (op)
      OP_NOP: ;
      OP_LDI: begin
        cls_o    = CLS_LDI;
        wb_sel_o = WB_IMM;
        imm_o    = sext_ldi(instr_i[LDI_IMM_W-1:0]);
      end
      OP_ADD: begin cls_o = CLS_ALU; alu_op_o = ALU_ADD; end
      OP_SUB: begin cls_o = CLS_ALU; alu_op_o = ALU_SUB; end
      OP_AND: begin cls_o = CLS_ALU; alu_op_o = ALU_AND; end
      OP_OR:  begin cls_o = CLS_ALU; alu_op_o = ALU_OR;  end
      OP_XOR: begin cls_o = CLS_ALU; alu_op_o = ALU_XOR; end
      OP_MOV: begin cls_o = CLS_MOV; wb_sel_o = WB_RS;   end
      OP_LD:  begin cls_o = CLS_LD;  wb_sel_o = WB_MEM;  end
      OP_ST:  cls_o = CLS_ST;
      OP_JMP: begin
        cls_o = CLS_JMP;
        imm_o = {{(DATA_W-JMP_IMM_W){1'b0}}, instr_i[JMP_IMM_W-1:0]};
      end
      OP_JZ: begin
        cls_o = CLS_JZ;
        imm_o = {{(DATA_W-JMP_IMM_W){1'b0}}, instr_i[JMP_IMM_W-1:0]};
      end
      OP_HALT: cls_o = CLS_HALT;
      // Undefined opcodes fall through as a NOP with the illegal flag raised.
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller driving IR, PC and
// register-file strobes from the instruction held in the external IR.
module cpu_control_fsm #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mem_ready,
  input  logic [DATA_W-1:0]  ir_in,
  input  logic               alu_zero,
  output logic               ir_en,
  output logic               pc_inc,
  output logic               pc_load,
  output logic               mem_read,
  output logic               mem_write,
  output logic               addr_sel,
  output logic               reg_we,
  output logic [RADDR_W-1:0] rd_addr,
  output logic [RADDR_W-1:0] rs_addr,
  output logic [RADDR_W-1:0] rt_addr,
  output logic [2:0]         alu_op,
  output logic [1:0]         wb_sel,
  output logic [DATA_W-1:0]  imm_out,
  output logic               halted,
  output logic               illegal,
  output logic [2:0]         dbg_state_o
);
  import cpu_pkg::*;

  // Memory handshake: mem_read/mem_write is a request held high, unchanged,
  // until the cycle mem_ready is also high; that cycle completes the access.

  state_e              state_q, state_d;
  instr_class_e        cls_q, cls_d;
  logic [RADDR_W-1:0]  rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
  logic [2:0]          alu_op_q, alu_op_d;
  logic [1:0]          wb_sel_q, wb_sel_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic                illegal_q, illegal_d;

  logic ir_en_s, pc_inc_s, pc_load_s, mem_read_s, mem_write_s;
  logic addr_sel_s, reg_we_s, halted_s;

  instr_class_e        dec_cls;
  logic [2:0]          dec_alu_op;
  logic [1:0]          dec_wb_sel;
  logic [DATA_W-1:0]   dec_imm;
  logic                dec_illegal;

  cpu_instr_decode u_decode (
    .instr_i   (ir_in),
    .cls_o     (dec_cls),
    .alu_op_o  (dec_alu_op),
    .wb_sel_o  (dec_wb_sel),
    .imm_o     (dec_imm),
    .illegal_o (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cls_q     <= CLS_NOP;
      rd_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      alu_op_q  <= '0;
      wb_sel_q  <= '0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      rd_q      <= rd_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      alu_op_q  <= alu_op_d;
      wb_sel_q  <= wb_sel_d;
      imm_q     <= imm_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    rd_d        = rd_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    alu_op_d    = alu_op_q;
    wb_sel_d    = wb_sel_q;
    imm_d       = imm_q;
    illegal_d   = illegal_q;
    ir_en_s     = 1'b0;
    pc_inc_s    = 1'b0;
    pc_load_s   = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    addr_sel_s  = 1'b0;
    reg_we_s    = 1'b0;
    halted_s    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_read_s = 1'b1;
        if (mem_ready) begin
          ir_en_s  = 1'b1;
          pc_inc_s = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // IR was written at the previous edge, so ir_in is the new word here.
        cls_d    = dec_cls;
        rd_d     = ir_in[RD_LSB +: RADDR_W];
        rs_d     = ir_in[RS_LSB +: RADDR_W];
        rt_d     = ir_in[RT_LSB +: RADDR_W];
        alu_op_d = dec_alu_op;
        wb_sel_d = dec_wb_sel;
        imm_d    = dec_imm;
        if (dec_illegal) illegal_d = 1'b1;
        case (dec_cls)
          CLS_NOP:  state_d = S_FETCH;
          CLS_HALT: state_d = S_HALT;
          default:  state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          CLS_ALU, CLS_LDI, CLS_MOV: state_d = S_WB;
          CLS_LD: state_d = S_MEM;
          CLS_ST: begin
            mem_write_s = 1'b1;
            addr_sel_s  = 1'b1;
            if (mem_ready) state_d = S_FETCH;
          end
          CLS_JMP: begin
            pc_load_s = 1'b1;
            state_d   = S_FETCH;
          end
          CLS_JZ: begin
            pc_load_s = alu_zero;
            state_d   = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_read_s = 1'b1;
        addr_sel_s = 1'b1;
        if (mem_ready) state_d = S_WB;
      end
      S_WB: begin
        reg_we_s = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        halted_s = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset silences every output in the same cycle, so an aborted
  // instruction cannot complete a strobe while rst is high.
  always_comb begin
    ir_en     = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr_sel  = 1'b0;
    reg_we    = 1'b0;
    rd_addr   = '0;
    rs_addr   = '0;
    rt_addr   = '0;
    alu_op    = '0;
    wb_sel    = '0;
    imm_out   = '0;
    halted    = 1'b0;
    illegal   = 1'b0;
    if (!rst) begin
      ir_en     = ir_en_s;
      pc_inc    = pc_inc_s;
      pc_load   = pc_load_s;
      mem_read  = mem_read_s;
      mem_write = mem_write_s;
      addr_sel  = addr_sel_s;
      reg_we    = reg_we_s;
      rd_addr   = rd_q;
      rs_addr   = rs_q;
      rt_addr   = rt_q;
      alu_op    = alu_op_q;
      wb_sel    = wb_sel_q;
      imm_out   = imm_q;
      halted    = halted_s;
      illegal   = illegal_q;
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: drivers push expected strobe events,
// a negedge monitor pops and compares them as the DUT raises them.
module tb_cpu_control_fsm;

  localparam int W = 54;
  localparam int K_NOP = 0, K_WB = 1, K_LD = 2, K_ST = 3, K_JMP = 4, K_JZ = 5, K_HALT = 6;
  // strobe order: ir_en pc_inc pc_load mem_read mem_write addr_sel reg_we
  localparam logic [6:0] EV_FETCH = 7'b1101000;
  localparam logic [6:0] EV_MEMRD = 7'b0001010;
  localparam logic [6:0] EV_MEMWR = 7'b0000110;
  localparam logic [6:0] EV_WB    = 7'b0000001;
  localparam logic [6:0] EV_PCLD  = 7'b0010000;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, mem_ready, alu_zero;
  logic [15:0] ir_reg, mem_data;
  logic        ir_en, pc_inc, pc_load, mem_read, mem_write, addr_sel, reg_we;
  logic [2:0]  rd_addr, rs_addr, rt_addr, alu_op, dbg_state;
  logic [1:0]  wb_sel;
  logic [15:0] imm_out;
  logic        halted, illegal;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [2:0]  p_rd, p_rs, p_rt, p_alu;
  logic [1:0]  p_wb;
  logic [15:0] p_imm;
  logic        p_ill;

  cpu_control_fsm #(.DATA_W(16), .RADDR_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_ready(mem_ready),
    .ir_in(ir_reg), .alu_zero(alu_zero),
    .ir_en(ir_en), .pc_inc(pc_inc), .pc_load(pc_load),
    .mem_read(mem_read), .mem_write(mem_write), .addr_sel(addr_sel),
    .reg_we(reg_we), .rd_addr(rd_addr), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .alu_op(alu_op), .wb_sel(wb_sel), .imm_out(imm_out),
    .halted(halted), .illegal(illegal), .dbg_state_o(dbg_state)
  );

  // external IR register loaded from memory data on ir_en
  always @(posedge clk) begin
    if (rst) ir_reg <= 16'h0;
    else if (ir_en) ir_reg <= mem_data;
  end

  function automatic logic [W-1:0] pk(input int c, input logic [6:0] s,
                                      input logic [2:0] rd, input logic [2:0] rs,
                                      input logic [2:0] rt, input logic [2:0] al,
                                      input logic [1:0] wb, input logic [15:0] im,
                                      input logic il);
    return {c[15:0], s, rd, rs, rt, al, wb, im, il};
  endfunction

  function automatic logic [63:0] all_out();
    return {25'd0, ir_en, pc_inc, pc_load, mem_read, mem_write, addr_sel, reg_we,
            rd_addr, rs_addr, rt_addr, alu_op, wb_sel, imm_out, halted, illegal};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input logic [6:0] s);
    exp_q.push_back(pk(cyc, s, p_rd, p_rs, p_rt, p_alu, p_wb, p_imm, p_ill));
  endtask

  // scoreboard monitor
  logic [W-1:0] mon_act, mon_exp;
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((ir_en && pc_load) || (mem_read && mem_write) || (pc_inc && pc_load)) begin
        errors++;
        $display("FAIL strobe_excl cyc=%0d got=%b%b%b%b exp=no_overlap",
                 cyc, ir_en, pc_inc, pc_load, mem_write);
      end
      if (ir_en || pc_load || mem_write || reg_we || (mem_read && addr_sel)) begin
        mon_act = pk(cyc, {ir_en, pc_inc, pc_load, mem_read, mem_write, addr_sel, reg_we},
                     rd_addr, rs_addr, rt_addr, alu_op, wb_sel, imm_out, illegal);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event got=%h exp=none", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_act !== mon_exp) begin
            errors++;
            $display("FAIL event cyc=%0d got=%h exp=%h", cyc, mon_act, mon_exp);
          end
        end
      end
    end
  end

  // Driver: entered during a FETCH cycle, returns in the next FETCH (or HALT).
  task automatic run_instr(input string nm, input logic [15:0] word, input int fw,
                           input int mw, input logic zero, input int kind,
                           input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt,
                           input logic [2:0] al, input logic [1:0] wb,
                           input logic [15:0] im, input logic ill);
    mem_data = word;
    alu_zero = zero;
    mem_ready = 1'b0;
    for (int i = 0; i < fw; i++) tick();
    mem_ready = 1'b1;
    push_ev(EV_FETCH);
    tick();
    mem_ready = 1'b0;
    tick();
    p_rd = rd; p_rs = rs; p_rt = rt; p_alu = al; p_wb = wb; p_imm = im;
    p_ill = p_ill | ill;
    case (kind)
      K_WB: begin
        tick();
        push_ev(EV_WB);
        tick();
      end
      K_LD: begin
        tick();
        for (int i = 0; i <= mw; i++) begin
          mem_ready = (i == mw);
          push_ev(EV_MEMRD);
          tick();
        end
        mem_ready = 1'b0;
        push_ev(EV_WB);
        tick();
      end
      K_ST: begin
        for (int i = 0; i <= mw; i++) begin
          mem_ready = (i == mw);
          push_ev(EV_MEMWR);
          tick();
        end
      end
      K_JMP: begin
        push_ev(EV_PCLD);
        tick();
      end
      K_JZ: begin
        if (zero) push_ev(EV_PCLD);
        tick();
      end
      default: ;
    endcase
    mem_ready = 1'b0;
    if (kind != K_HALT) begin
      #1;
      chk({nm, "_refetch"}, 64'({mem_read, addr_sel, ir_en, mem_write}), 64'h8);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0; mem_data = 16'h0;
    p_rd = '0; p_rs = '0; p_rt = '0; p_alu = '0; p_wb = '0; p_imm = '0; p_ill = 1'b0;

    @(negedge clk);
    chk("rst_outputs_0", all_out(), 64'h0);
    @(negedge clk);
    chk("rst_outputs_1", all_out(), 64'h0);
    chk("rst_state", 64'(dbg_state), 64'h0);
    #1;
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("fetch_entry", 64'({mem_read, addr_sel, ir_en, pc_inc}), 64'h8);

    run_instr("add_wait", 16'h2298, 2, 0, 1'b0, K_WB, 3'd1, 3'd2, 3'd3, 3'd0, 2'd0, 16'h0000, 1'b0);
    run_instr("ldi_neg",  16'h13FF, 0, 0, 1'b0, K_WB, 3'd1, 3'd7, 3'd7, 3'd0, 2'd1, 16'hFFFF, 1'b0);
    run_instr("sub",      16'h3A50, 0, 0, 1'b0, K_WB, 3'd5, 3'd1, 3'd2, 3'd1, 2'd0, 16'h0000, 1'b0);
    run_instr("xor",      16'h6E38, 1, 0, 1'b0, K_WB, 3'd7, 3'd0, 3'd7, 3'd4, 2'd0, 16'h0000, 1'b0);
    run_instr("mov",      16'h7C40, 0, 0, 1'b0, K_WB, 3'd6, 3'd1, 3'd0, 3'd0, 2'd3, 16'h0000, 1'b0);
    run_instr("ld",       16'h8280, 0, 1, 1'b0, K_LD, 3'd1, 3'd2, 3'd0, 3'd0, 2'd2, 16'h0000, 1'b0);
    run_instr("st",       16'h9098, 0, 0, 1'b0, K_ST, 3'd0, 3'd2, 3'd3, 3'd0, 2'd0, 16'h0000, 1'b0);
    run_instr("jz_taken", 16'hB00A, 0, 0, 1'b1, K_JZ, 3'd0, 3'd0, 3'd1, 3'd0, 2'd0, 16'h000A, 1'b0);
    run_instr("jz_not",   16'hB00A, 0, 0, 1'b0, K_JZ, 3'd0, 3'd0, 3'd1, 3'd0, 2'd0, 16'h000A, 1'b0);
    run_instr("jmp",      16'hA123, 0, 0, 1'b0, K_JMP, 3'd0, 3'd4, 3'd4, 3'd0, 2'd0, 16'h0123, 1'b0);
    run_instr("st_wait",  16'h9098, 1, 2, 1'b0, K_ST, 3'd0, 3'd2, 3'd3, 3'd0, 2'd0, 16'h0000, 1'b0);
    run_instr("nop",      16'h0000, 0, 0, 1'b0, K_NOP, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000, 1'b0);
    run_instr("illegal",  16'hC000, 0, 0, 1'b0, K_NOP, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000, 1'b1);
    chk("illegal_set", 64'(illegal), 64'h1);
    run_instr("nop_after_ill", 16'h0000, 0, 0, 1'b0, K_NOP, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000, 1'b0);
    chk("illegal_sticky", 64'(illegal), 64'h1);

    // ADD aborted by reset in its EXEC cycle
    mem_data = 16'h2298;
    mem_ready = 1'b1;
    push_ev(EV_FETCH);
    tick();
    mem_ready = 1'b0;
    tick();
    p_rd = 3'd1; p_rs = 3'd2; p_rt = 3'd3; p_alu = 3'd0; p_wb = 2'd0; p_imm = 16'h0;
    chk("exec_state", 64'(dbg_state), 64'h3);
    rst = 1'b1;
    #1;
    chk("rst_exec_outputs", all_out(), 64'h0);
    tick();
    rst = 1'b0;
    p_rd = '0; p_rs = '0; p_rt = '0; p_alu = '0; p_wb = '0; p_imm = '0; p_ill = 1'b0;
    #1;
    chk("rst_to_idle", 64'({dbg_state, illegal}), 64'h0);
    tick(); tick(); tick();
    chk("idle_quiet", all_out(), 64'h0);

    start = 1'b1;
    tick();
    start = 1'b0;
    run_instr("halt", 16'hF000, 0, 0, 1'b0, K_HALT, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      start = (i % 3 == 0);
      mem_ready = (i % 2 == 1);
      #1;
      chk("halt_hold", 64'({halted, ir_en, pc_inc, pc_load, mem_read, mem_write, addr_sel, reg_we}),
          64'h80);
      tick();
    end
    start = 1'b0;
    mem_ready = 1'b0;
    chk("halt_state", 64'(dbg_state), 64'h6);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
